keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Drives and scans a 4x4 matrix keypad, debounces presses, and emits one `key_valid` pulse with a 4-bit `key_code` per accepted press.
- Sits directly upstream of the setup and PIN-entry FSMs, which consume `key_valid`/`key_code`.
- Code 4'hF (the `#` key) is the enter/confirm key; codes 0-9 are digits.

Parameters:
- COL_DWELL, 1000, clock cycles each column is driven before stepping to the next (minimum 4).
- DEBOUNCE_SCANS, 20, consecutive identical full-scan results required to accept a press or a release (minimum 2).
- REPEAT_DELAY, 50, full scans held before the first auto-repeat (used only with the optional feature).
- REPEAT_RATE, 10, full scans between auto-repeats (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- row_in  in  4  keypad rows, active-low, externally pulled up, asynchronous to clk
- col_out  out  4  column drive, active-low, exactly one bit low at all times
- key_valid  out  1  one-cycle pulse per accepted key event
- key_code  out  4  code of the last accepted key; holds its value between pulses
- key_held  out  1  high while an accepted key remains debounced-pressed

Behaviour:
- Reset (rst low, asynchronous):
  - col_out=4'b1110, key_valid=0, key_code=0, key_held=0.
  - All counters are 0 and the FSM is in IDLE.
  - Reset asserted mid-operation discards any partial debounce; no pulse is emitted.
- Synchronizer: row_in passes through a 2-flop synchronizer; only the synchronized value is used.
- Column scan:
  - A dwell counter counts 0..COL_DWELL-1.
  - On the last dwell cycle, the synchronized rows are sampled for the current column, then col_out rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110 (wrap-around).
  - A scan_done strobe fires on the last dwell cycle of column 3.
  - Full scan period is 4*COL_DWELL cycles.
- Key map (row r low while column c is driven; rows top-to-bottom, columns left-to-right):
  - row 0: 1 2 3 A
  - row 1: 4 5 6 B
  - row 2: 7 8 9 C
  - row 3: `*`=E, 0, `#`=F, D
- Scan result per full scan: NONE (no low row), SINGLE(k) (exactly one key low), or MULTI (two or more). MULTI is treated exactly like NONE.
- Debounce FSM, evaluated only on scan_done; cnt is a counter sized $clog2(DEBOUNCE_SCANS+1):
  - IDLE: on SINGLE(k), set cand=k, cnt=1, go to DEB_PRESS.
  - DEB_PRESS:
    - result==SINGLE(cand): cnt++.
    - When cnt reaches DEBOUNCE_SCANS: set key_code=cand, pulse key_valid in the following cycle, set key_held=1, go to PRESSED.
    - Any other result: return to IDLE with no pulse.
  - PRESSED: result != SINGLE(cand) sets cnt=1 and goes to DEB_RELEASE.
  - DEB_RELEASE:
    - result==SINGLE(cand): return to PRESSED.
    - Otherwise cnt++. When cnt reaches DEBOUNCE_SCANS: key_held=0, go to IDLE.
- Rolling presses: a second key pressed while the first is held is never accepted until the FSM passes through IDLE. Exactly one pulse is emitted per physical press.
- Latency: key_valid rises 1 cycle after the scan_done of the DEBOUNCE_SCANS-th consecutive matching scan. key_code is updated in the same cycle key_valid rises.
- key_valid is never high for two consecutive cycles.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - In PRESSED, with cand in 0-9 only, a scan counter re-emits key_valid (same key_code) after REPEAT_DELAY scans, then every REPEAT_RATE scans.
  - The scan counter resets on leaving PRESSED.
  - Keys A-F never repeat.
- Undefined: no repeat logic is synthesized; one pulse per press.

Test Plan (COL_DWELL=4, DEBOUNCE_SCANS=3, REPEAT_DELAY=5, REPEAT_RATE=2; scan = 16 cycles):
- Reset: hold rst low, then release; rows idle -> col_out=1110 and rotates every 4 cycles; key_valid=0, key_code=0, key_held=0 for 200 cycles.
- Clean press of '5' (row1 low while col1 driven), held 10 scans -> exactly one key_valid pulse with key_code=5, 1 cycle after the 3rd scan_done; key_held=1. On release, key_held falls after 3 clean scans; no further pulses.
- Bouncy '#' (row3/col2 toggling every 5 cycles for 48 cycles, then stable) -> exactly one pulse, key_code=F; none during the bounce.
- '1' and '2' held simultaneously 6 scans, then '2' released -> no pulse while both are held; a single pulse with key_code=1 after 3 further scans.
- rst pulsed low after 2 matching scans of '7' -> no pulse, outputs reset. After rst rises with '7' still held -> pulse with key_code=7 after 3 more scans.
- With KEYPAD_REPEAT_EN, hold '3' 12 scans -> pulses at scan 3, scan 8, then every 2 scans. Hold 'A' 12 scans -> single pulse only.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, 2-flop row sync, scan-level debounce, one pulse per press.
// Optional auto-repeat of digit keys when KEYPAD_REPEAT_EN is defined.
//
// state       | meaning
// IDLE        | no key candidate
// DEB_PRESS   | counting matching scans of a new candidate
// PRESSED     | key accepted and held
// DEB_RELEASE | counting non-matching scans before release
module keypad_scanner #(
  parameter int COL_DWELL      = 1000,
  parameter int DEBOUNCE_SCANS = 20,
  parameter int REPEAT_DELAY   = 50,
  parameter int REPEAT_RATE    = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int DW = $clog2(COL_DWELL);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_RELEASE} state_t;

  state_t          state, state_nxt;
  logic [3:0]      row_s1, row_s2;
  logic [DW-1:0]   dwell_cnt;
  logic [1:0]      col_idx;
  logic            last_dwell, scan_done;
  logic [1:0]      acc_hits, tot_hits;
  logic [3:0]      acc_code, scan_code, col_code;
  logic [2:0]      col_hits, hit_sum;
  logic [1:0]      col_row;
  logic            res_single, match;
  logic [CW-1:0]   cnt, cnt_nxt, cnt_inc;
  logic [3:0]      cand, cand_nxt, code_nxt;
  logic            held_nxt, valid_nxt;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'b0000: key_map = 4'h1;
      4'b0001: key_map = 4'h2;
      4'b0010: key_map = 4'h3;
      4'b0011: key_map = 4'hA;
      4'b0100: key_map = 4'h4;
      4'b0101: key_map = 4'h5;
      4'b0110: key_map = 4'h6;
      4'b0111: key_map = 4'hB;
      4'b1000: key_map = 4'h7;
      4'b1001: key_map = 4'h8;
      4'b1010: key_map = 4'h9;
      4'b1011: key_map = 4'hC;
      4'b1100: key_map = 4'hE;
      4'b1101: key_map = 4'h0;
      4'b1110: key_map = 4'hF;
      default: key_map = 4'hD;
    endcase
  endfunction

  assign col_out    = ~(4'b0001 << col_idx);
  assign last_dwell = (dwell_cnt == DW'(COL_DWELL - 1));
  assign scan_done  = last_dwell && (col_idx == 2'd3);

  // Per-column decode, merged into a saturating hit count across the scan (2 means MULTI).
  always_comb begin
    col_hits = '0;
    col_row  = '0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_s2[r]) begin
        col_hits = col_hits + 3'd1;
        col_row  = 2'(r);
      end
    end
    col_code   = key_map(col_row, col_idx);
    hit_sum    = {1'b0, acc_hits} + col_hits;
    tot_hits   = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    scan_code  = (acc_hits != 2'd0) ? acc_code : col_code;
    res_single = (tot_hits == 2'd1);
    match      = res_single && (scan_code == cand);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_s1    <= 4'hF;
      row_s2    <= 4'hF;
      dwell_cnt <= '0;
      col_idx   <= '0;
      acc_hits  <= '0;
      acc_code  <= '0;
    end else begin
      row_s1 <= row_in;
      row_s2 <= row_s1;
      if (last_dwell) begin
        dwell_cnt <= '0;
        col_idx   <= col_idx + 2'd1;
        acc_hits  <= scan_done ? 2'd0 : tot_hits;
        acc_code  <= scan_done ? 4'h0 : scan_code;
      end else begin
        dwell_cnt <= dwell_cnt + DW'(1);
      end
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  logic [RW-1:0] rep_cnt, rep_nxt;
`endif

  assign cnt_inc = cnt + CW'(1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cand_nxt  = cand;
    code_nxt  = key_code;
    held_nxt  = key_held;
    valid_nxt = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_nxt   = rep_cnt;
`endif
    if (scan_done) begin
      case (state)
        IDLE: begin
          if (res_single) begin
            cand_nxt  = scan_code;
            cnt_nxt   = CW'(1);
            state_nxt = DEB_PRESS;
          end
        end
        DEB_PRESS: begin
          if (match) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
              code_nxt  = cand;
              valid_nxt = 1'b1;
              held_nxt  = 1'b1;
              state_nxt = PRESSED;
`ifdef KEYPAD_REPEAT_EN
              rep_nxt   = RW'(REPEAT_DELAY);
`endif
            end
          end else begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end
        PRESSED: begin
          if (!match) begin
            cnt_nxt   = CW'(1);
            state_nxt = DEB_RELEASE;
`ifdef KEYPAD_REPEAT_EN
            rep_nxt   = '0;
          end else if (cand <= 4'h9) begin
            if (rep_cnt == RW'(1)) begin
              valid_nxt = 1'b1;
              rep_nxt   = RW'(REPEAT_RATE);
            end else begin
              rep_nxt   = rep_cnt - RW'(1);
            end
`endif
          end
        end
        default: begin
          if (match) begin
            state_nxt = PRESSED;
`ifdef KEYPAD_REPEAT_EN
            rep_nxt   = RW'(REPEAT_DELAY);
`endif
          end else begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
              cnt_nxt   = '0;
              held_nxt  = 1'b0;
              state_nxt = IDLE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      key_code  <= '0;
      key_held  <= 1'b0;
      key_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cand      <= cand_nxt;
      key_code  <= code_nxt;
      key_held  <= held_nxt;
      key_valid <= valid_nxt;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= rep_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix driving row_in from col_out.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [15:0] pressed;

  int n_checks = 0;
  int n_fail   = 0;

  keypad_scanner #(
    .COL_DWELL(4), .DEBOUNCE_SCANS(3), .REPEAT_DELAY(5), .REPEAT_RATE(2)
  ) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
    .key_valid(key_valid), .key_code(key_code), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // Key index = row*4 + col; a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  int         wraps = 0;
  int         pulses = 0;
  int         pulse_wrap = 0;
  int         consec_err = 0;
  logic [3:0] last_code = 4'h0;
  logic [3:0] prev_col = 4'hF;
  logic       prev_valid = 1'b0;

  always @(negedge clk) begin
    if (col_out == 4'b1110 && prev_col == 4'b0111) wraps = wraps + 1;
    prev_col = col_out;
    if (key_valid) begin
      pulses     = pulses + 1;
      last_code  = key_code;
      pulse_wrap = wraps;
      if (prev_valid) consec_err = consec_err + 1;
    end
    prev_valid = key_valid;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_wraps(input int n);
    int target = wraps + n;
    int guard  = 0;
    while (wraps < target && guard < n * 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (wraps < target) check_val("wrap_timeout", wraps, target);
  endtask

`ifdef KEYPAD_REPEAT_EN
  localparam int EXP5_PULSES = 3;
  localparam int EXP5_LAST   = 10;
`else
  localparam int EXP5_PULSES = 1;
  localparam int EXP5_LAST   = 3;
`endif

  initial begin
    int w0, p0, cyc;
    logic seen;
    rst     = 1'b0;
    pressed = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_col", 32'(col_out), 32'hE);
    check_val("rst_valid", 32'(key_valid), 0);
    check_val("rst_code", 32'(key_code), 0);
    check_val("rst_held", 32'(key_held), 0);
    @(posedge clk);
    #1 rst = 1'b1;

    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("idle_col", 32'(col_out), 32'(~(4'b0001 << ((k / 4) % 4)) & 4'hF));
    end
    check_val("idle_pulses", pulses, 0);
    check_val("idle_held", 32'(key_held), 0);
    check_val("idle_code", 32'(key_code), 0);

    // Clean '5'
    wait_wraps(1);
    pressed[5] = 1'b1;
    w0 = wraps;
    p0 = pulses;
    wait_wraps(10);
    check_val("k5_pulses", pulses - p0, EXP5_PULSES);
    check_val("k5_code", 32'(last_code), 5);
    check_val("k5_latency", pulse_wrap, w0 + EXP5_LAST);
    check_val("k5_held", 32'(key_held), 1);
    pressed[5] = 1'b0;
    p0 = pulses;
    wait_wraps(2);
    check_val("k5_held_rel2", 32'(key_held), 1);
    wait_wraps(1);
    check_val("k5_held_rel3", 32'(key_held), 0);
    check_val("k5_no_extra", pulses - p0, 0);

    // Bouncy '#'
    wait_wraps(1);
    p0 = pulses;
    for (int i = 0; i < 48; i++) begin
      pressed[14] = ((i / 5) % 2) == 0;
      @(posedge clk);
      #1;
    end
    check_val("hash_bounce", pulses - p0, 0);
    pressed[14] = 1'b1;
    wait_wraps(5);
    check_val("hash_pulses", pulses - p0, 1);
    check_val("hash_code", 32'(last_code), 32'hF);
    pressed = '0;
    wait_wraps(4);
    check_val("hash_rel", 32'(key_held), 0);

    // '1' and '2' together, then '2' released
    wait_wraps(1);
    p0 = pulses;
    pressed[0] = 1'b1;
    pressed[1] = 1'b1;
    wait_wraps(6);
    check_val("multi_none", pulses - p0, 0);
    check_val("multi_held", 32'(key_held), 0);
    pressed[1] = 1'b0;
    w0 = wraps;
    wait_wraps(4);
    check_val("roll_pulses", pulses - p0, 1);
    check_val("roll_code", 32'(last_code), 1);
    check_val("roll_latency", pulse_wrap, w0 + 3);
    pressed = '0;
    wait_wraps(4);

    // Reset during debounce of '7'
    wait_wraps(1);
    p0 = pulses;
    pressed[8] = 1'b1;
    wait_wraps(2);
    rst = 1'b0;
    #1;
    check_val("mid_rst_col", 32'(col_out), 32'hE);
    check_val("mid_rst_code", 32'(key_code), 0);
    check_val("mid_rst_held", 32'(key_held), 0);
    check_val("mid_rst_valid", 32'(key_valid), 0);
    repeat (5) @(posedge clk);
    check_val("mid_rst_nopulse", pulses - p0, 0);
    #1 rst = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (key_valid) seen = 1'b1;
    end
    check_val("k7_latency", cyc, 48);
    check_val("k7_code", 32'(key_code), 7);
    wait_wraps(3);
    check_val("k7_pulses", pulses - p0, 1);
    pressed = '0;
    wait_wraps(4);

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat: digit repeats, letter does not
    wait_wraps(1);
    p0 = pulses;
    pressed[2] = 1'b1;
    w0 = wraps;
    wait_wraps(12);
    check_val("rep3_pulses", pulses - p0, 4);
    check_val("rep3_last", pulse_wrap, w0 + 12);
    check_val("rep3_code", 32'(last_code), 3);
    pressed = '0;
    wait_wraps(4);
    wait_wraps(1);
    p0 = pulses;
    pressed[3] = 1'b1;
    wait_wraps(12);
    check_val("repA_pulses", pulses - p0, 1);
    check_val("repA_code", 32'(last_code), 32'hA);
    pressed = '0;
    wait_wraps(4);
`endif

    check_val("valid_consec", consec_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
